// File: rtl/fetch.sv
// Instruction fetch stage with IF/ID pipeline register and a one-entry skid
// buffer that catches the word returning from imem while decode is stalled.
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_vld,
  output logic        o_misalign
);

  logic [31:0] pc_q, pc_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        req_en;
  logic [31:0] req_pc;

  logic        vld_d;
  logic [31:0] inst_d, pc_out_d, nxt_pc_d;
  logic        mis_d;

  // Request side: redirect beats hold, hold suppresses the request entirely.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    req_en    = 1'b0;
    req_pc    = pc_q;
    pc_d      = pc_q;
    infl_d    = 1'b0;
    infl_pc_d = infl_pc_q;
    if (i_redirect) begin
      req_en = 1'b1;
      req_pc = i_redirect_pc;
    end else if (!i_hold) begin
      req_en = 1'b1;
      req_pc = pc_q;
    end
    if (req_en) begin
      pc_d      = req_pc + 32'd4;
      infl_d    = 1'b1;
      infl_pc_d = req_pc;
    end
  end

  assign o_imem_ren   = req_en & ~i_rst;
  assign o_imem_raddr = {req_pc[31:2], 2'b00};

  // IF/ID and skid update; the skid always drains before fresh memory data.
  always_comb begin
    vld_d       = o_vld;
    inst_d      = o_inst;
    pc_out_d    = o_pc;
    nxt_pc_d    = o_nxt_pc;
    mis_d       = o_misalign;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (i_redirect) begin
      vld_d      = 1'b0;
      inst_d     = NOP_INST;
      mis_d      = 1'b0;
      skid_vld_d = 1'b0;
    end else if (i_hold) begin
      if (infl_q) begin
        skid_vld_d  = 1'b1;
        skid_inst_d = i_imem_rdata;
        skid_pc_d   = infl_pc_q;
      end
    end else if (skid_vld_q) begin
      vld_d    = 1'b1;
      inst_d   = skid_inst_q;
      pc_out_d = skid_pc_q;
      nxt_pc_d = skid_pc_q + 32'd4;
      mis_d    = |skid_pc_q[1:0];
      if (infl_q) begin
        skid_inst_d = i_imem_rdata;
        skid_pc_d   = infl_pc_q;
      end else begin
        skid_vld_d = 1'b0;
      end
    end else if (infl_q) begin
      vld_d    = 1'b1;
      inst_d   = i_imem_rdata;
      pc_out_d = infl_pc_q;
      nxt_pc_d = infl_pc_q + 32'd4;
      mis_d    = |infl_pc_q[1:0];
    end else begin
      vld_d  = 1'b0;
      inst_d = NOP_INST;
      mis_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q        <= RESET_ADDR;
      infl_q      <= 1'b0;
      infl_pc_q   <= 32'd0;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= 32'd0;
      o_vld       <= 1'b0;
      o_inst      <= NOP_INST;
      o_pc        <= 32'd0;
      o_nxt_pc    <= 32'd0;
      o_misalign  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_pc_q   <= infl_pc_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      o_vld       <= vld_d;
      o_inst      <= inst_d;
      o_pc        <= pc_out_d;
      o_nxt_pc    <= nxt_pc_d;
      o_misalign  <= mis_d;
    end
  end

  // A held cycle never issues a request, so a second word cannot arrive
  // while the skid is still occupied.
  always @(posedge i_clk) begin
    if (!i_rst && !i_redirect && i_hold && infl_q)
      assert (!skid_vld_q) else $error("fetch: skid overflow");
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: synchronous imem model returning addr+0x100.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        redir;
  logic [31:0] redir_pc;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic [31:0] inst, pc, nxt_pc;
  logic        vld, mis;

  int errors = 0;
  int checks = 0;

  fetch dut (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_redirect(redir),
    .i_redirect_pc(redir_pc), .o_imem_ren(ren), .o_imem_raddr(raddr),
    .i_imem_rdata(rdata), .o_inst(inst), .o_pc(pc), .o_nxt_pc(nxt_pc),
    .o_vld(vld), .o_misalign(mis)
  );

  always #5 clk = ~clk;

  // Poison the read port when not requested so stale data is caught.
  always @(posedge clk) rdata <= ren ? (raddr + 32'h100) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] p);
    check({tag, " vld"}, {31'd0, vld}, {31'd0, v});
    check({tag, " inst"}, inst, i);
    check({tag, " pc"}, pc, p);
    check({tag, " nxt"}, nxt_pc, p + 32'd4);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; redir = 1'b0; redir_pc = 32'd0;
    tick(); tick();
    check("rst vld", {31'd0, vld}, 32'd0);
    check("rst inst", inst, NOP);
    check("rst pc", pc, 32'd0);
    check("rst nxt", nxt_pc, 32'd0);
    check("rst mis", {31'd0, mis}, 32'd0);
    check("rst ren", {31'd0, ren}, 32'd0);

    // Streaming from reset
    rst = 1'b0; #1;
    check("first ren", {31'd0, ren}, 32'd1);
    check("first raddr", raddr, 32'h0);
    tick();
    check("first vld", {31'd0, vld}, 32'd0);
    check("raddr 4", raddr, 32'h4);
    tick(); chk_out("s0", 1'b1, 32'h100, 32'h0);
    check("raddr 8", raddr, 32'h8);
    tick(); chk_out("s1", 1'b1, 32'h104, 32'h4);
    tick(); chk_out("s2", 1'b1, 32'h108, 32'h8);

    // Three-cycle hold with 0xC in flight
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("hold ren", {31'd0, ren}, 32'd0);
      tick(); chk_out("hold", 1'b1, 32'h108, 32'h8);
    end
    hold = 1'b0; #1;
    check("rel raddr", raddr, 32'h10);
    tick(); chk_out("skid", 1'b1, 32'h10C, 32'hC);

    // Redirect while 0x10 is in flight
    redir = 1'b1; redir_pc = 32'h40; #1;
    check("redir raddr", raddr, 32'h40);
    tick();
    check("flush vld", {31'd0, vld}, 32'd0);
    check("flush inst", inst, NOP);
    redir = 1'b0;
    tick(); chk_out("tgt", 1'b1, 32'h140, 32'h40);
    tick(); chk_out("tgt+4", 1'b1, 32'h144, 32'h44);

    // Fill the skid, then hold+redirect together
    hold = 1'b1;
    tick(); chk_out("hold2", 1'b1, 32'h144, 32'h44);
    redir = 1'b1; redir_pc = 32'h80; #1;
    check("hr ren", {31'd0, ren}, 32'd1);
    check("hr raddr", raddr, 32'h80);
    tick();
    check("hr vld", {31'd0, vld}, 32'd0);
    hold = 1'b0; redir = 1'b0;
    tick(); chk_out("hr tgt", 1'b1, 32'h180, 32'h80);
    tick(); chk_out("hr tgt+4", 1'b1, 32'h184, 32'h84);

    // Misaligned target
    redir = 1'b1; redir_pc = 32'h42; #1;
    check("mis raddr", raddr, 32'h40);
    tick(); redir = 1'b0;
    tick(); chk_out("mis", 1'b1, 32'h140, 32'h42);
    check("mis flag", {31'd0, mis}, 32'd1);

    // Wrap at top of address space
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC; #1;
    check("wrap raddr", raddr, 32'hFFFF_FFFC);
    tick(); redir = 1'b0;
    tick(); chk_out("top", 1'b1, 32'h0000_00FC, 32'hFFFF_FFFC);
    check("top nxt0", nxt_pc, 32'h0);
    check("top mis", {31'd0, mis}, 32'd0);
    tick(); chk_out("wrap", 1'b1, 32'h100, 32'h0);

    // Async reset mid-stall with the skid full
    hold = 1'b1;
    tick(); chk_out("pre rst", 1'b1, 32'h100, 32'h0);
    #2 rst = 1'b1; #1;
    check("arst vld", {31'd0, vld}, 32'd0);
    check("arst inst", inst, NOP);
    check("arst ren", {31'd0, ren}, 32'd0);
    tick();
    hold = 1'b0; rst = 1'b0; #1;
    check("restart ren", {31'd0, ren}, 32'd1);
    check("restart raddr", raddr, 32'h0);
    tick();
    check("restart vld", {31'd0, vld}, 32'd0);
    tick(); chk_out("restart", 1'b1, 32'h100, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage and IF/ID pipeline register; sits directly upstream of the decode stage.
- Generates the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents the instruction to decode as o_inst/o_pc/o_nxt_pc/o_vld.
- Honours the decode stall (o_hold from decode drives i_hold) and the execute-stage redirect for branches and jumps, using a 1-entry skid buffer so no fetched word is lost.

Parameters:
RESET_ADDR, 32'h0000_0000, address of the first fetch after reset
NOP_INST, 32'h0000_0013, instruction word presented on bubbles (addi x0,x0,0)

Ports:
i_clk  input  1  global clock, all state on posedge
i_rst  input  1  reset, asynchronous, active-high
i_hold  input  1  stall from decode; IF/ID register and PC must hold
i_redirect  input  1  taken branch/jal/jalr from execute; flush and refetch
i_redirect_pc  input  32  redirect target
o_imem_ren  output  1  instruction memory read enable
o_imem_raddr  output  32  instruction memory word address (bits[1:0] forced 0)
i_imem_rdata  input  32  read data, valid the cycle after a ren=1 request
o_inst  output  32  IF/ID instruction
o_pc  output  32  IF/ID PC of o_inst
o_nxt_pc  output  32  IF/ID o_pc+4, wraps mod 2^32
o_vld  output  1  IF/ID holds a real instruction
o_misalign  output  1  o_pc[1:0]!=0; qualified by o_vld

Behaviour:
- Reset (asynchronous, any time, including mid-fetch or mid-stall):
  - pc_q=RESET_ADDR; inflight=0; skid empty.
  - o_vld=0, o_inst=NOP_INST, o_pc=0, o_nxt_pc=0, o_misalign=0, o_imem_ren=0.
- Internal state: pc_q (next address to request); inflight (request issued last cycle and not cancelled) with its pc; skid valid/inst/pc.
- Request logic, evaluated each cycle with rst=0, in priority order:
  - i_redirect=1: ren=1, raddr={i_redirect_pc[31:2],2'b00}; pc_q<=i_redirect_pc+4; inflight<=1 tagged with i_redirect_pc.
  - i_hold=1: ren=0; pc_q held. The memory's data is not consumed while held, so at most one word is outstanding.
  - Otherwise: ren=1, raddr=pc_q; pc_q<=pc_q+4; inflight<=1 tagged with pc_q.
- Latency: the address is issued in cycle N; the instruction appears on o_inst in cycle N+1 after the posedge, i.e. visible during cycle N+2 to decode logic.
- Returning data (inflight=1) has three outcomes:
  - i_redirect=1: dropped.
  - i_hold=1 and skid empty: captured into the skid.
  - i_hold=1 and skid full: cannot occur; assert in simulation.
- IF/ID update, in priority order:
  - i_redirect=1: o_vld<=0, o_inst<=NOP_INST; skid cleared; overrides i_hold (the older instruction wins).
  - i_hold=1: all IF/ID outputs hold their values.
  - Else if skid valid: load from the skid and clear it. Any same-cycle returning data moves into the skid.
  - Else if inflight: load i_imem_rdata with the inflight pc; o_vld<=1.
  - Else: bubble (o_vld<=0, o_inst<=NOP_INST, o_pc/o_nxt_pc hold).
- Ordering: instructions leave strictly in address order; no word is duplicated or lost across any hold pattern.
- o_nxt_pc=o_pc+4 and o_misalign=(o_pc[1:0]!=0) are both registered with o_pc.
- A misaligned redirect target is fetched with masked address bits; o_pc keeps the unmasked value.
- PC wrap: 32'hFFFF_FFFC+4=32'h0000_0000, no flag.
- i_hold and i_redirect in the same cycle: the redirect takes effect and the hold is ignored for that cycle.
- First cycle after reset release: ren=1, raddr=RESET_ADDR, o_vld=0.

Test Plan:
- Reset release with imem[i]=i*4+0x100 and no hold → raddr 0,4,8…; o_vld=1 one cycle after the first ren; o_inst 0x100,0x104,0x108; o_nxt_pc=o_pc+4.
- i_hold=1 for 3 cycles mid-stream while o_pc=0x8 → outputs frozen at 0x8; ren=0 for 3 cycles; after release the sequence continues 0xC,0x10 with no gap or duplicate (data taken from the skid).
- i_redirect=1 with i_redirect_pc=0x40 while 0x10 is in flight → next o_vld=0; 0x10 is never presented; the following o_pc=0x40, then 0x44.
- i_hold=1 and i_redirect=1 together with target 0x80 → flush occurs; the skid is cleared; o_pc=0x80 two cycles later.
- Redirect to 0x42 → raddr=0x40; o_pc=0x42, o_misalign=1; redirect to 0xFFFF_FFFC → next o_pc=0x0000_0000.
- Assert i_rst asynchronously between clock edges mid-stall with the skid full → o_vld=0 and o_inst=NOP_INST immediately; after release the fetch restarts at RESET_ADDR.
